// File: rtl/filter_glb_loader.sv
// ----------------------------------------------------------------------------
// filter_glb_loader
//
// Upstream feeder for one PE. On start it reads a run of `length` filter
// weights from the global buffer (GLB) SRAM beginning at `base_addr`. It packs
// PACK weights per word (lane 0 = earliest weight) and pushes each word into
// the PE filter FIFO. FIFO back-pressure is honoured without dropping or
// duplicating weights. A final partial word has its unused upper lanes zeroed.
//
// Ports
//   clk               clock, single domain
//   reset             asynchronous, active-low reset
//   start             begin a run; sampled only while idle
//   base_addr         first GLB address, latched on start
//   length            weights in the run, latched on start
//   busy              high from the accepted start through the done cycle
//   done              one-cycle pulse once the last word has been pushed
//   glb_rd_en         GLB synchronous read request
//   glb_addr          GLB read address, valid with glb_rd_en (0 otherwise)
//   glb_rd_data       GLB read data, valid one cycle after glb_rd_en
//   filter            packed word presented to the PE filter FIFO
//   push_filter       FIFO write strobe; the word is accepted whenever high
//   filter_fifo_full  PE filter FIFO full
// ----------------------------------------------------------------------------
module filter_glb_loader #(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned PACK              = 4,
    parameter int unsigned DATA_WIDTH_FILTER = 64,
    parameter int unsigned ADDR_WIDTH        = 12,
    parameter int unsigned LEN_WIDTH         = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [LEN_WIDTH-1:0]         length,
    output logic                         busy,
    output logic                         done,
    output logic                         glb_rd_en,
    output logic [ADDR_WIDTH-1:0]        glb_addr,
    input  logic [DATA_WIDTH-1:0]        glb_rd_data,
    output logic [DATA_WIDTH_FILTER-1:0] filter,
    output logic                         push_filter,
    input  logic                         filter_fifo_full
);

    localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [LaneW-1:0] LastLane = LaneW'(PACK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         base_q, base_d;
    logic [LEN_WIDTH-1:0]          len_q, len_d;
    logic [LEN_WIDTH-1:0]          issued_q, issued_d;   // reads issued so far
    logic [LaneW-1:0]              ilane_q, ilane_d;     // lane of the next read to issue
    logic                          inflight_q, inflight_d;
    logic [LaneW-1:0]              fl_lane_q, fl_lane_d; // lane of the read in flight
    logic                          fl_flush_q, fl_flush_d; // in-flight read completes a word
    logic [DATA_WIDTH_FILTER-1:0]  pack_q, pack_d;
    logic [DATA_WIDTH_FILTER-1:0]  out_q, out_d;
    logic                          out_valid_q, out_valid_d;

    // ------------------------------------------------------------------
    // Read issue and handshake decode
    // ------------------------------------------------------------------
    logic                          last_rd;
    logic                          completing;
    logic                          out_busy;
    logic                          rd_en;
    logic                          push;
    logic [DATA_WIDTH_FILTER-1:0]  merged;

    assign last_rd    = (issued_q + LEN_WIDTH'(1)) == len_q;
    assign completing = (ilane_q == LastLane) || last_rd;

    // The out register counts as occupied while a word-completing read is
    // still in flight; otherwise a short final word issued right behind a
    // full word would land on top of it.
    assign out_busy   = out_valid_q || (inflight_q && fl_flush_q);

    assign rd_en = (state_q == StFetch) && (issued_q != len_q) && !(completing && out_busy);
    assign push  = out_valid_q && !filter_fifo_full;

    // Drop the returning weight into its lane of the pack register.
    always_comb begin
        merged = pack_q;
        for (int unsigned k = 0; k < PACK; k++) begin
            if (fl_lane_q == LaneW'(k)) begin
                merged[k*DATA_WIDTH +: DATA_WIDTH] = glb_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        ilane_d     = ilane_q;
        inflight_d  = rd_en;
        fl_lane_d   = ilane_q;
        fl_flush_d  = rd_en && completing;
        pack_d      = pack_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    ilane_d  = '0;
                    state_d  = (length == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (issued_q == len_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The word being pushed this cycle empties the out register.
                if (!inflight_q && (!out_valid_q || push)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rd_en) begin
            issued_d = issued_q + LEN_WIDTH'(1);
            ilane_d  = completing ? '0 : ilane_q + LaneW'(1);
        end

        if (push) begin
            out_valid_d = 1'b0;
        end

        if (inflight_q) begin
            if (fl_flush_q) begin
                out_d       = merged;
                out_valid_d = 1'b1;
                pack_d      = '0;
            end else begin
                pack_d = merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            ilane_q     <= '0;
            inflight_q  <= 1'b0;
            fl_lane_q   <= '0;
            fl_flush_q  <= 1'b0;
            pack_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            ilane_q     <= ilane_d;
            inflight_q  <= inflight_d;
            fl_lane_q   <= fl_lane_d;
            fl_flush_q  <= fl_flush_d;
            pack_q      <= pack_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign glb_rd_en   = rd_en;
    assign glb_addr    = rd_en ? (base_q + ADDR_WIDTH'(issued_q)) : '0;
    assign filter      = out_q;
    assign push_filter = push;

endmodule

// File: tb/tb_filter_glb_loader.sv
// ----------------------------------------------------------------------------
// Testbench for filter_glb_loader: a GLB memory model answers reads one cycle
// later, a reference model queues the expected addresses and packed words of
// each run, and a monitor compares every read and push against those queues.
// ----------------------------------------------------------------------------
module tb_filter_glb_loader;

    localparam int DW = 16;
    localparam int PK = 4;
    localparam int FW = 64;
    localparam int AW = 12;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          glb_rd_en;
    logic [AW-1:0] glb_addr;
    logic [DW-1:0] glb_rd_data;
    logic [FW-1:0] filter;
    logic          push_filter;
    logic          full;

    always #5 clk = ~clk;

    filter_glb_loader #(
        .DATA_WIDTH        (DW),
        .PACK              (PK),
        .DATA_WIDTH_FILTER (FW),
        .ADDR_WIDTH        (AW),
        .LEN_WIDTH         (LW)
    ) dut (
        .clk              (clk),
        .reset            (rst_n),
        .start            (start),
        .base_addr        (base_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .glb_rd_en        (glb_rd_en),
        .glb_addr         (glb_addr),
        .glb_rd_data      (glb_rd_data),
        .filter           (filter),
        .push_filter      (push_filter),
        .filter_fifo_full (full)
    );

    logic [DW-1:0] mem [1<<AW];

    // Synchronous GLB: data for a request appears in the following cycle only.
    always @(posedge clk) begin
        if (glb_rd_en) glb_rd_data <= mem[glb_addr];
        else           glb_rd_data <= 16'hdead;
    end

    int            checks = 0;
    int            failures = 0;
    logic [FW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            cyc_global = 0;
    int            last_push_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference model: the run's address sequence and its packed words.
    task automatic expect_run(input logic [AW-1:0] b, input int len);
        int            nw;
        logic [FW-1:0] word;
        logic [AW-1:0] a;
        nw = (len + PK - 1) / PK;
        for (int i = 0; i < len; i++) begin
            a = b + AW'(i);
            addr_q.push_back(a);
        end
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int k = 0; k < PK; k++) begin
                if (w * PK + k < len) begin
                    a = b + AW'(w * PK + k);
                    word[k*DW +: DW] = mem[a];
                end
            end
            exp_q.push_back(word);
        end
    endtask

    // Monitor: every read and push is checked against the model queues.
    always @(negedge clk) begin
        cyc_global++;
        if (rst_n) begin
            if (glb_rd_en) begin
                if (addr_q.size() == 0) fail("unexpected_read");
                else check("glb_addr", 64'(glb_addr), 64'(addr_q.pop_front()));
            end
            if (push_filter) begin
                last_push_cyc = cyc_global;
                if (exp_q.size() == 0) fail("unexpected_push");
                else check("filter_word", filter, exp_q.pop_front());
            end
            if (done) begin
                check("done_with_busy", 64'(busy), 64'(1));
                check("words_left_at_done", 64'(exp_q.size()), 64'(0));
                check("reads_left_at_done", 64'(addr_q.size()), 64'(0));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_rd_en"}, 64'(glb_rd_en), 64'(0));
        check({tag, "_push"}, 64'(push_filter), 64'(0));
        check({tag, "_addr"}, 64'(glb_addr), 64'(0));
        check({tag, "_filter"}, filter, 64'(0));
    endtask

    // mode: 0 FIFO never full, 1 random full, 2 full during cycles 6..15.
    // exp_lat: required start-to-done cycle count (0 = not checked).
    // abort_cyc: pull reset in that cycle and abandon the run (0 = never).
    task automatic run(input logic [AW-1:0] b, input int len, input int mode,
                       input int exp_lat, input int abort_cyc, input bit restart);
        int            cyc;
        bit            got;
        logic [FW-1:0] hold_word;
        cyc = 0;
        got = 1'b0;
        expect_run(b, len);
        hold_word = (exp_q.size() > 0) ? exp_q[0] : '0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        length    = LW'(len);
        full      = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        while (!got && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            start = restart && (cyc == 3);
            if (restart && cyc == 3) begin
                base_addr = AW'($urandom);
                length    = LW'($urandom_range(1, 50));
            end
            if (mode == 1)      full = 1'($urandom_range(0, 1));
            else if (mode == 2) full = (cyc >= 6 && cyc <= 15);
            else                full = 1'b0;
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrun_reset");
                exp_q.delete();
                addr_q.delete();
                full  = 1'b0;
                start = 1'b0;
                return;
            end
            @(negedge clk); #1;
            if (mode == 2 && cyc >= 6 && cyc <= 15) begin
                check("held_no_push", 64'(push_filter), 64'(0));
                check("held_filter", filter, hold_word);
                if (cyc == 15) check("stalled_read", 64'(glb_rd_en), 64'(0));
            end
            if (done) got = 1'b1;
        end
        full  = 1'b0;
        start = 1'b0;
        if (!got) begin
            fail("done_timeout");
        end else begin
            if (exp_lat > 0) check("done_latency", 64'(cyc), 64'(exp_lat));
            if (len == 0) check("len0_done_within_2", 64'(cyc <= 2), 64'(1));
            if (mode == 0 && len > 0)
                check("done_after_last_push", 64'(cyc_global - last_push_cyc), 64'(1));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        full      = 1'b0;
        base_addr = '0;
        length    = '0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Directed runs with GLB[a] = a.
        run(12'h010, 8, 0, 11, 0, 1'b0);
        run(12'h010, 5, 0, 0, 0, 1'b0);
        run(12'h030, 4, 0, 7, 0, 1'b0);
        run(12'h010, 8, 2, 0, 0, 1'b0);
        run(12'h010, 0, 0, 0, 0, 1'b0);
        run(12'h010, 8, 0, 0, 4, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(12'h020, 4, 0, 7, 0, 1'b0);
        run(12'h010, 8, 0, 11, 0, 1'b1);
        run(12'hffe, 6, 1, 0, 0, 1'b0);

        // Randomized runs over random GLB contents and random back-pressure.
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
        for (int r = 0; r < 25; r++) begin
            run(AW'($urandom), $urandom_range(0, 40), 1, 0, 0, 1'b0);
        end
        run(AW'($urandom), 511, 1, 0, 0, 1'b0);
        run(AW'($urandom), 13, 0, 0, 0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("final_idle", 64'(busy), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
